// File: rtl/mode_ctrl.sv
// Top-level piano mode controller: qualifies one-hot mode switches over a stability window,
// defers changes while the active engine is busy, and blinks the LEDs on invalid selections.
module mode_ctrl #(
  parameter int NUM_MODES    = 3,
  parameter int DEFAULT_MODE = 0,
  parameter int HOLD_CYCLES  = 4,
  parameter int BLINK_DIV    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_MODES-1:0] sel_in,
  input  logic                 busy,
  output logic [NUM_MODES-1:0] mode,
  output logic                 mode_valid,
  output logic                 mode_chg,
  output logic [NUM_MODES-1:0] mode_led,
  output logic                 err
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [NUM_MODES-1:0] DEF_MODE = NUM_MODES'(1) << DEFAULT_MODE;
  localparam logic [CNT_W-1:0]     HOLD_MAX = CNT_W'(HOLD_CYCLES);
  localparam logic [BLK_W-1:0]     BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    WAIT_IDLE,
    ERR
  } state_t;

  state_t               state, state_n;
  logic [NUM_MODES-1:0] sel_q;
  logic [NUM_MODES-1:0] pend, pend_n;
  logic [NUM_MODES-1:0] mode_n;
  logic [CNT_W-1:0]     stab_cnt;
  logic [BLK_W-1:0]     blink_cnt, blink_cnt_n;
  logic                 phase, phase_n;
  logic                 chg_n;
  logic                 qual;
  logic                 legal;

  assign qual  = (stab_cnt == HOLD_MAX);
  assign legal = ($countones(sel_q) == 1);

  // Qualifier: stab_cnt counts how long sel_in has matched its previous sample.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      stab_cnt <= '0;
    end else begin
      sel_q <= sel_in;
      if (sel_in != sel_q) begin
        stab_cnt <= '0;
      end else if (!qual) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    pend_n      = pend;
    chg_n       = 1'b0;
    blink_cnt_n = '0;
    phase_n     = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (qual) begin
          if (!legal) begin
            state_n = ERR;
            mode_n  = '0;
            chg_n   = 1'b1;
            phase_n = 1'b1;
          end else if (sel_q != mode) begin
            if (busy) begin
              pend_n  = sel_q;
              state_n = WAIT_IDLE;
            end else begin
              mode_n = sel_q;
              chg_n  = 1'b1;
            end
          end
        end
      end
      WAIT_IDLE: begin
        // Any disturbance of the pending selection drops it; it must re-qualify from ACTIVE.
        if (!qual || (sel_q != pend)) begin
          state_n = ACTIVE;
        end else if (!busy) begin
          mode_n  = pend;
          chg_n   = 1'b1;
          state_n = ACTIVE;
        end
      end
      ERR: begin
        if (qual && legal) begin
          mode_n  = sel_q;
          chg_n   = 1'b1;
          state_n = ACTIVE;
        end else if (blink_cnt == BLK_LAST) begin
          phase_n = ~phase;
        end else begin
          blink_cnt_n = blink_cnt + BLK_W'(1);
          phase_n     = phase;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end

  // Outputs are registered from next-state values so they all move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACTIVE;
      mode       <= DEF_MODE;
      pend       <= '0;
      mode_chg   <= 1'b0;
      mode_valid <= 1'b1;
      err        <= 1'b0;
      mode_led   <= DEF_MODE;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      pend       <= pend_n;
      mode_chg   <= chg_n;
      mode_valid <= (state_n != ERR);
      err        <= (state_n == ERR);
      mode_led   <= (state_n == ERR) ? {NUM_MODES{phase_n}} : mode_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
    end
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl: directed scenarios plus randomized switch/busy/reset
// traffic, compared each cycle against a sample-history reference model.
module tb_mode_ctrl;

  localparam int N     = 3;
  localparam int DEF   = 0;
  localparam int HOLD  = 4;
  localparam int BLINK = 8;

  localparam int S_ACT  = 0;
  localparam int S_WAIT = 1;
  localparam int S_ERR  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sel_in;
  logic         busy;
  logic [N-1:0] mode;
  logic         mode_valid;
  logic         mode_chg;
  logic [N-1:0] mode_led;
  logic         err;

  mode_ctrl #(
    .NUM_MODES   (N),
    .DEFAULT_MODE(DEF),
    .HOLD_CYCLES (HOLD),
    .BLINK_DIV   (BLINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_in    (sel_in),
    .busy      (busy),
    .mode      (mode),
    .mode_valid(mode_valid),
    .mode_chg  (mode_chg),
    .mode_led  (mode_led),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: recent sel_in samples plus spec-level mode state.
  logic [N-1:0] hist[$];
  int           m_st;
  logic [N-1:0] m_mode;
  logic [N-1:0] m_pend;
  logic         m_chg;
  int           err_age;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit stable_long_enough();
    if (hist.size() < HOLD + 1) return 1'b0;
    foreach (hist[i]) if (hist[i] !== hist[hist.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [N-1:0] q;
    bit           ok;
    bit           lg;
    if (rst) begin
      hist.delete();
      hist.push_back('0);
      m_st    = S_ACT;
      m_mode  = N'(1) << DEF;
      m_pend  = '0;
      m_chg   = 1'b0;
      err_age = 0;
      return;
    end
    q     = hist[hist.size()-1];
    ok    = stable_long_enough();
    lg    = ($countones(q) == 1);
    m_chg = 1'b0;
    case (m_st)
      S_ACT: begin
        if (ok && !lg) begin
          m_st = S_ERR; m_mode = '0; m_chg = 1'b1; err_age = 0;
        end else if (ok && q != m_mode) begin
          if (busy) begin m_pend = q; m_st = S_WAIT; end
          else begin m_mode = q; m_chg = 1'b1; end
        end
      end
      S_WAIT: begin
        if (!ok || q != m_pend) m_st = S_ACT;
        else if (!busy) begin m_mode = m_pend; m_chg = 1'b1; m_st = S_ACT; end
      end
      default: begin
        if (ok && lg) begin m_mode = q; m_chg = 1'b1; m_st = S_ACT; end
        else err_age++;
      end
    endcase
    hist.push_back(sel_in);
    if (hist.size() > HOLD + 1) void'(hist.pop_front());
  endtask

  task automatic check_all();
    logic [N-1:0] exp_led;
    if (m_st == S_ERR) exp_led = (((err_age / BLINK) % 2) == 0) ? '1 : '0;
    else               exp_led = m_mode;
    check("mode", 32'(mode), 32'(m_mode));
    check("mode_valid", 32'(mode_valid), 32'(m_st != S_ERR));
    check("err", 32'(err), 32'(m_st == S_ERR));
    check("mode_chg", 32'(mode_chg), 32'(m_chg));
    check("mode_led", 32'(mode_led), 32'(exp_led));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic run(input logic [N-1:0] s, input logic b, input int n);
    sel_in = s;
    busy   = b;
    repeat (n) cycle();
  endtask

  initial begin
    int burst;
    rst    = 1'b1;
    sel_in = 3'b001;
    busy   = 1'b0;
    hist.push_back('0);
    m_st = S_ACT; m_mode = 3'b001; m_pend = '0; m_chg = 1'b0; err_age = 0;

    // Reset state.
    repeat (2) cycle();
    check("rst_mode", 32'(mode), 32'h1);
    check("rst_led", 32'(mode_led), 32'h1);
    check("rst_valid", 32'(mode_valid), 32'h1);
    rst = 1'b0;
    run(3'b001, 1'b0, 8);

    // Plain switch: change lands on the sixth edge after the new value is first sampled.
    run(3'b010, 1'b0, 5);
    check("pre_switch_mode", 32'(mode), 32'h1);
    cycle();
    check("switch_mode", 32'(mode), 32'h2);
    check("switch_pulse", 32'(mode_chg), 32'h1);
    cycle();
    check("switch_pulse_end", 32'(mode_chg), 32'h0);

    // Glitch inside the stability window.
    run(3'b001, 1'b0, 8);
    run(3'b010, 1'b0, 2);
    run(3'b100, 1'b0, 10);
    check("glitch_final", 32'(mode), 32'h4);

    // Busy defers, release applies.
    run(3'b001, 1'b0, 8);
    run(3'b100, 1'b1, 16);
    check("busy_hold", 32'(mode), 32'h1);
    run(3'b100, 1'b0, 1);
    check("busy_release", 32'(mode), 32'h4);
    check("busy_release_pulse", 32'(mode_chg), 32'h1);

    // Selection changed while waiting: cancel, then re-qualify.
    run(3'b001, 1'b1, 8);
    run(3'b010, 1'b1, 2);
    run(3'b010, 1'b0, 8);
    check("cancel_requal", 32'(mode), 32'h2);

    // Multi-hot selection: error with blinking LEDs, busy ignored.
    run(3'b011, 1'b1, 6);
    check("err_flag", 32'(err), 32'h1);
    check("err_mode", 32'(mode), 32'h0);
    check("err_led_first", 32'(mode_led), 32'h7);
    run(3'b011, 1'b1, 40);
    run(3'b001, 1'b1, 6);
    check("err_exit", 32'(mode), 32'h1);

    // Reset while waiting discards the pending mode.
    run(3'b100, 1'b1, 8);
    rst = 1'b1;
    run(3'b001, 1'b0, 1);
    check("rst_wait_mode", 32'(mode), 32'h1);
    rst = 1'b0;
    run(3'b001, 1'b0, 10);
    check("rst_wait_after", 32'(mode), 32'h1);

    // Reset while in error.
    run(3'b110, 1'b0, 8);
    rst = 1'b1;
    run(3'b001, 1'b0, 1);
    check("rst_err_flag", 32'(err), 32'h0);
    check("rst_err_led", 32'(mode_led), 32'h1);
    rst = 1'b0;
    run(3'b001, 1'b0, 6);

    // Randomized traffic.
    repeat (150) begin
      if ($urandom_range(0, 9) < 7) sel_in = N'(1) << $urandom_range(0, N-1);
      else                          sel_in = N'($urandom_range(0, 7));
      busy  = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 40) == 0);
      burst = $urandom_range(1, 9);
      for (int i = 0; i < burst; i++) begin
        cycle();
        rst = 1'b0;
        if ($urandom_range(0, 5) == 0) busy = ~busy;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
